// File: rtl/serial_parallel_divider_pkg.sv
// Shared arithmetic package for the serial-parallel multiplier/divider pair:
// FSM state encodings and two's-complement magnitude helpers.
package serial_parallel_divider_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    // Helpers work on a 32-bit container. Callers zero-extend a narrower
    // operand and keep the low bits of the result. The low bits of a
    // negation do not depend on the upper bits, so this is exact for any
    // width up to 32.
    function automatic logic [31:0] twos_negate(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    function automatic logic [31:0] twos_abs(input logic [31:0] x, input logic neg);
        return neg ? twos_negate(x) : x;
    endfunction

endpackage

// File: rtl/serial_parallel_divider_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, then subtract the divisor magnitude if it fits.
module div_restore_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // Compare/subtract on the WIDTH+1-bit shifted remainder. When the top bit
    // is set the value already exceeds any WIDTH-bit divisor, and the wrapped
    // WIDTH-bit difference is exact because the result is below the divisor.
    always_comb begin
        shifted = {rem_in, q_in[WIDTH-1]};
        ge      = shifted[WIDTH] || (shifted[WIDTH-1:0] >= divisor_mag);
        diff    = shifted[WIDTH-1:0] - divisor_mag;
        rem_out = ge ? diff : shifted[WIDTH-1:0];
        q_out   = {q_in[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/serial_parallel_divider.sv
// Sequential signed restoring divider, one quotient bit per clock.
// Operands are taken on start while idle; results come back with a done pulse.
module serial_parallel_divider
    import serial_parallel_divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int             CW      = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state, next_state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_r, q_r, dmag_r;
    logic             dvd_neg_r, dvs_neg_r, dz_r, ovf_r;

    logic             accept, step_en, fix_en;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH-1:0] rem_nxt, q_nxt;
    logic [WIDTH-1:0] q_neg, rem_neg;

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_in      (rem_r),
        .q_in        (q_r),
        .divisor_mag (dmag_r),
        .rem_out     (rem_nxt),
        .q_out       (q_nxt)
    );

    // Operand magnitudes and result negations; |MIN| fits as unsigned WIDTH bits.
    always_comb begin
        dvd_mag = WIDTH'(twos_abs(32'(dividend), dividend[WIDTH-1]));
        dvs_mag = WIDTH'(twos_abs(32'(divisor), divisor[WIDTH-1]));
        q_neg   = WIDTH'(twos_negate(32'(q_r)));
        rem_neg = WIDTH'(twos_negate(32'(rem_r)));
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // FSM next-state logic; a zero divisor skips the iteration entirely.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start) next_state = (divisor == '0) ? ST_FIX : ST_RUN;
            ST_RUN:  if (cnt == LAST) next_state = ST_FIX;
            ST_FIX:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // FSM outputs: busy spans accept edge to done edge; start is ignored while busy.
    always_comb begin
        busy    = (state != ST_IDLE);
        accept  = (state == ST_IDLE) && start;
        step_en = (state == ST_RUN);
        fix_en  = (state == ST_FIX);
    end

    // Datapath: load operands, iterate restoring steps, then sign-fix the results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            rem_r       <= '0;
            q_r         <= '0;
            dmag_r      <= '0;
            dvd_neg_r   <= 1'b0;
            dvs_neg_r   <= 1'b0;
            dz_r        <= 1'b0;
            ovf_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                cnt       <= '0;
                rem_r     <= '0;
                q_r       <= dvd_mag;
                dmag_r    <= dvs_mag;
                dvd_neg_r <= dividend[WIDTH-1];
                dvs_neg_r <= divisor[WIDTH-1];
                dz_r      <= (divisor == '0);
                ovf_r     <= (dividend == MIN_VAL) && (divisor == '1);
            end else if (step_en) begin
                cnt   <= cnt + CW'(1);
                rem_r <= rem_nxt;
                q_r   <= q_nxt;
            end else if (fix_en) begin
                done        <= 1'b1;
                div_by_zero <= dz_r;
                overflow    <= ovf_r;
                if (dz_r) begin
                    // q_r still holds |dividend|; re-signing it restores the dividend.
                    quotient  <= '1;
                    remainder <= dvd_neg_r ? q_neg : q_r;
                end else begin
                    // MIN / -1 leaves q_r = |MIN| with equal signs, i.e. the wrapped MIN.
                    quotient  <= (dvd_neg_r ^ dvs_neg_r) ? q_neg : q_r;
                    remainder <= dvd_neg_r ? rem_neg : rem_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_parallel_divider.sv
// Directed and random checks of the 8-bit signed serial divider.
module tb_serial_parallel_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend, divisor;
    logic [7:0] quotient, remainder;
    logic       busy, done, div_by_zero, overflow;

    int checks = 0;
    int errors = 0;

    serial_parallel_divider #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at #1 after an edge with busy low: drives start for one cycle,
    // then waits (bounded) for done. lat = edges after the accept edge; 0 on timeout.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat, output int bcnt);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        bcnt  = busy ? 1 : 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (busy) bcnt++;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic chk_res(input string tag, input logic [7:0] eq, input logic [7:0] er,
                           input logic edz, input logic eov);
        chk({tag, " quotient"},  32'(quotient),    32'(eq));
        chk({tag, " remainder"}, 32'(remainder),   32'(er));
        chk({tag, " dbz"},       32'(div_by_zero), 32'(edz));
        chk({tag, " ovf"},       32'(overflow),    32'(eov));
    endtask

    initial begin
        int lat, bcnt, seen;
        int ai, bi, qq, rr;
        logic [7:0] a, b, eq, er;
        logic edz, eov;

        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst quotient",  32'(quotient),  32'd0);
        chk("rst remainder", 32'(remainder), 32'd0);
        chk("rst busy",      32'(busy),      32'd0);
        chk("rst done",      32'(done),      32'd0);
        chk("rst dbz",       32'(div_by_zero), 32'd0);
        chk("rst ovf",       32'(overflow),  32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 100 / 7: latency, busy width, single-cycle done
        run_op(8'd100, 8'd7, lat, bcnt);
        chk("100/7 latency", 32'(lat), 32'd9);
        chk("100/7 busy cycles", 32'(bcnt), 32'd9);
        chk_res("100/7", 8'd14, 8'd2, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("100/7 done width", 32'(done), 32'd0);

        // sign combinations
        run_op(8'd156, 8'd7, lat, bcnt);      // -100 / 7
        chk_res("-100/7", 8'hF2, 8'hFE, 1'b0, 1'b0);
        run_op(8'd100, 8'hF9, lat, bcnt);     // 100 / -7
        chk_res("100/-7", 8'hF2, 8'd2, 1'b0, 1'b0);
        run_op(8'd156, 8'hF9, lat, bcnt);     // -100 / -7
        chk_res("-100/-7", 8'd14, 8'hFE, 1'b0, 1'b0);

        // divide by zero, then a normal op clears the flag
        run_op(8'd5, 8'd0, lat, bcnt);
        chk("5/0 latency", 32'(lat), 32'd1);
        chk_res("5/0", 8'hFF, 8'd5, 1'b1, 1'b0);
        run_op(8'hEC, 8'd0, lat, bcnt);       // -20 / 0
        chk_res("-20/0", 8'hFF, 8'hEC, 1'b1, 1'b0);

        // overflow, then cleared by 127 / 1
        run_op(8'h80, 8'hFF, lat, bcnt);
        chk("-128/-1 latency", 32'(lat), 32'd9);
        chk_res("-128/-1", 8'h80, 8'd0, 1'b0, 1'b1);
        run_op(8'd127, 8'd1, lat, bcnt);
        chk_res("127/1", 8'd127, 8'd0, 1'b0, 1'b0);
        run_op(8'h80, 8'd1, lat, bcnt);       // MIN / 1 is not overflow
        chk_res("-128/1", 8'h80, 8'd0, 1'b0, 1'b0);

        // start pulse while busy is ignored, then back-to-back start after done
        dividend = 8'd100; divisor = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        dividend = 8'd50; divisor = 8'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dividend = 8'd3; divisor = 8'd3;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin seen = 1; break; end
            @(posedge clk); #1;
        end
        chk("busy-ignore done seen", 32'(seen), 32'd1);
        chk_res("busy-ignore 100/7", 8'd14, 8'd2, 1'b0, 1'b0);
        run_op(8'd50, 8'd5, lat, bcnt);
        chk("b2b latency", 32'(lat), 32'd9);
        chk_res("b2b 50/5", 8'd10, 8'd0, 1'b0, 1'b0);

        // reset four cycles into 100/7
        dividend = 8'd100; divisor = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("midrst quotient",  32'(quotient),  32'd0);
        chk("midrst remainder", 32'(remainder), 32'd0);
        chk("midrst busy",      32'(busy),      32'd0);
        chk("midrst done",      32'(done),      32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1;
        end
        chk("midrst no done", 32'(seen), 32'd0);
        run_op(8'd9, 8'd3, lat, bcnt);
        chk_res("post-rst 9/3", 8'd3, 8'd0, 1'b0, 1'b0);

        // random pairs against an integer reference model
        for (int n = 0; n < 300; n++) begin
            a = 8'($urandom_range(0, 255));
            b = (n % 25 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            if (n == 1) begin a = 8'h80; b = 8'hFF; end
            ai = int'($signed(a));
            bi = int'($signed(b));
            if (bi == 0) begin
                eq = 8'hFF; er = a; edz = 1'b1; eov = 1'b0;
            end else begin
                qq = ai / bi;
                rr = ai % bi;
                eq = qq[7:0]; er = rr[7:0]; edz = 1'b0;
                eov = (ai == -128) && (bi == -1);
            end
            run_op(a, b, lat, bcnt);
            chk("rand latency", 32'(lat), (bi == 0) ? 32'd1 : 32'd9);
            chk_res("rand", eq, er, edz, eov);
            if (!edz && !eov) begin
                chk("rand identity",
                    32'(int'($signed(quotient)) * bi + int'($signed(remainder))), 32'(ai));
                chk("rand rem sign",
                    32'((remainder == 8'd0) || (remainder[7] == a[7])), 32'd1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
